// File: rtl/sdram_frame_reader.sv
// Read-side frame streamer: reloads the SDRAM read FIFOs each frame, waits for prefetch,
// then pops both FIFOs together per VGA request and rebuilds the 30-bit RGB pixel.
module sdram_frame_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int RD_BASE     = 0,
  parameter int RD_MAX      = 307200,
  parameter int BURST_LEN   = 128,
  parameter int LOAD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iVGA_VS,
  input  logic        iVGA_REQ,
  input  logic [15:0] RD1_DATA,
  input  logic        RD1_EMPTY,
  input  logic [15:0] RD2_DATA,
  input  logic        RD2_EMPTY,
  output logic        RD1,
  output logic        RD2,
  output logic [22:0] RD1_ADDR,
  output logic [22:0] RD2_ADDR,
  output logic [22:0] RD1_MAX_ADDR,
  output logic [22:0] RD2_MAX_ADDR,
  output logic [7:0]  RD1_LENGTH,
  output logic [7:0]  RD2_LENGTH,
  output logic        RD1_LOAD,
  output logic        RD2_LOAD,
  output logic        RD1_CLK,
  output logic        RD2_CLK,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oPIX_VALID,
  output logic [15:0] oFRAME_CNT,
  output logic        oUNDERFLOW
);

  localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
  localparam int LOAD_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(PIX_TOTAL - 1);
  localparam logic [LOAD_W-1:0] LAST_LOAD = LOAD_W'(LOAD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, STREAM, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   pix_cnt;
  logic [LOAD_W-1:0]  load_cnt;
  logic               rd_load;
  logic               vs_q, vs_q2;
  logic               vs_fall;
  logic               both_ready;
  logic               pop;
  logic               unused_msb;

  assign RD1_ADDR     = 23'(RD_BASE);
  assign RD2_ADDR     = 23'(RD_BASE);
  assign RD1_MAX_ADDR = 23'(RD_MAX);
  assign RD2_MAX_ADDR = 23'(RD_MAX);
  assign RD1_LENGTH   = 8'(BURST_LEN);
  assign RD2_LENGTH   = 8'(BURST_LEN);
  assign RD1_CLK      = clk;
  assign RD2_CLK      = clk;
  assign RD1_LOAD     = rd_load;
  assign RD2_LOAD     = rd_load;

  // Bit 15 of each FIFO word is padding.
  assign unused_msb = RD1_DATA[15] ^ RD2_DATA[15];

  assign vs_fall    = vs_q2 & ~vs_q;
  assign both_ready = ~RD1_EMPTY & ~RD2_EMPTY;

  // NOTE: the pop is combinational so the show-ahead word is acknowledged in the same
  // cycle it is captured; a registered pop would consume the following word instead.
  assign pop = (state == STREAM) & iVGA_REQ & both_ready;
  assign RD1 = pop;
  assign RD2 = pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      load_cnt   <= '0;
      rd_load    <= 1'b0;
      // NOTE: the sync stages reset to the idle (high) level of VS so that leaving
      // reset cannot fabricate a falling edge.
      vs_q       <= 1'b1;
      vs_q2      <= 1'b1;
      oRed       <= '0;
      oGreen     <= '0;
      oBlue      <= '0;
      oPIX_VALID <= 1'b0;
      oFRAME_CNT <= '0;
      oUNDERFLOW <= 1'b0;
    end else begin
      vs_q       <= iVGA_VS;
      vs_q2      <= vs_q;
      oPIX_VALID <= 1'b0;

      case (state)
        IDLE: ;
        LOAD: begin
          pix_cnt <= '0;
          if (load_cnt == LAST_LOAD) begin
            state   <= FILL;
            rd_load <= 1'b0;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        FILL: begin
          if (iVGA_REQ) begin
            oPIX_VALID <= 1'b1;
            {oRed, oGreen, oBlue} <= '0;
            oUNDERFLOW <= 1'b1;
          end
          if (both_ready) state <= STREAM;
        end
        STREAM: begin
          if (iVGA_REQ) begin
            oPIX_VALID <= 1'b1;
            if (pop) begin
              oRed   <= RD2_DATA[9:0];
              oGreen <= {RD1_DATA[14:10], RD2_DATA[14:10]};
              oBlue  <= RD1_DATA[9:0];
            end else begin
              {oRed, oGreen, oBlue} <= '0;
              oUNDERFLOW <= 1'b1;
            end
            // Starved requests still advance the position so the frame stays aligned.
            if (pix_cnt == LAST_PIX) begin
              state      <= DONE;
              pix_cnt    <= '0;
              oFRAME_CNT <= oFRAME_CNT + 1'b1;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (iVGA_REQ) begin
            oPIX_VALID <= 1'b1;
            {oRed, oGreen, oBlue} <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      // NOTE: placed after the case so these non-blocking updates win over any state
      // or load assignment made above in the same cycle.
      if (vs_fall) begin
        state    <= LOAD;
        load_cnt <= '0;
        rd_load  <= 1'b1;
      end
    end
  end

endmodule
